// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction classes and decoded-record layout
// for the instruction-decode stage.
package decode_pkg;

  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int SFT_W    = 5;
  localparam int FUNC_W   = 6;
  localparam int IMM_W    = 16;
  localparam int ICLASS_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;

  // Opcodes with no meaning on this core; packed one per OP_W slice.
  localparam int N_ILLEGAL = 4;
  localparam logic [N_ILLEGAL*OP_W-1:0] ILLEGAL_OPS = {6'h3F, 6'h3E, 6'h3D, 6'h3C};

  typedef enum logic [ICLASS_W-1:0] {
    ICLASS_R   = 2'b00,
    ICLASS_I   = 2'b01,
    ICLASS_J   = 2'b10,
    ICLASS_ILL = 2'b11
  } iclass_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [SFT_W-1:0]  sftamt;
    logic [FUNC_W-1:0] func;
    logic [IMM_W-1:0]  immd16;
    iclass_e           iclass;
  } fields_t;

  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_ILLEGAL; i++) begin
      if (ILLEGAL_OPS[i*OP_W +: OP_W] == op) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational decoder: instruction word and its pc into the decoded record,
// extended immediate and absolute jump target.
module decode_fields
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic [31:0]       ins,
  input  logic [PC_W-1:0]   pc_in,
  output fields_t           fields,
  output logic [DATA_W-1:0] imm_ext,
  output logic [PC_W-1:0]   jtarget
);

  localparam logic [PC_W-1:0] SEG_MASK = ~PC_W'(28'hFFF_FFFF);

  function automatic iclass_e classify(input logic [OP_W-1:0] op);
    if (op == OP_RTYPE)                 return ICLASS_R;
    if ((op == OP_J) || (op == OP_JAL)) return ICLASS_J;
    if (is_illegal_op(op))              return ICLASS_ILL;
    return ICLASS_I;
  endfunction

  function automatic logic [DATA_W-1:0] extend_imm(input logic [OP_W-1:0] op,
                                                   input logic [IMM_W-1:0] imm);
    logic signed [IMM_W-1:0] imm_s;
    logic [31:0]             lui_word;
    imm_s    = signed'(imm);
    lui_word = {imm, 16'h0000};
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: return DATA_W'(imm);
      OP_LUI:                   return DATA_W'(lui_word);
      default:                  return DATA_W'(imm_s);
    endcase
  endfunction

  logic [PC_W-1:0] pc_plus4;

  always_comb begin
    fields.op     = ins[31:26];
    fields.rs     = ins[25:21];
    fields.rt     = ins[20:16];
    fields.rd     = ins[15:11];
    fields.sftamt = ins[10:6];
    fields.func   = ins[5:0];
    fields.immd16 = ins[15:0];
    fields.iclass = classify(ins[31:26]);
    imm_ext       = extend_imm(ins[31:26], ins[15:0]);
    // Segment bits come from pc+4, wrapping silently at the top of the space.
    pc_plus4      = pc_in + PC_W'(4);
    jtarget       = (pc_plus4 & SEG_MASK) | PC_W'({ins[25:0], 2'b00});
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: decodes at push time and buffers the decoded
// records in a DEPTH-entry FIFO with registered valid/ready handshakes.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            ins,
  input  logic [PC_W-1:0]        pc_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             op,
  output logic [5:0]             func,
  output logic [4:0]             sftamt,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [15:0]            immd16,
  output logic [DATA_W-1:0]      imm_ext,
  output logic [PC_W-1:0]        jtarget,
  output logic [1:0]             iclass,
  output logic [PC_W-1:0]        pc_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fields_t           dec_fields;
  logic [DATA_W-1:0] dec_imm;
  logic [PC_W-1:0]   dec_jt;

  decode_fields #(
    .DATA_W(DATA_W),
    .PC_W  (PC_W)
  ) u_fields (
    .ins    (ins),
    .pc_in  (pc_in),
    .fields (dec_fields),
    .imm_ext(dec_imm),
    .jtarget(dec_jt)
  );

  fields_t           fields_mem_q [DEPTH];
  logic [DATA_W-1:0] imm_mem_q    [DEPTH];
  logic [PC_W-1:0]   jt_mem_q     [DEPTH];
  logic [PC_W-1:0]   pc_mem_q     [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push, pop;

  // Both handshakes depend only on registered occupancy.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; contents are meaningless while out_valid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      fields_mem_q[wr_ptr_q] <= dec_fields;
      imm_mem_q[wr_ptr_q]    <= dec_imm;
      jt_mem_q[wr_ptr_q]     <= dec_jt;
      pc_mem_q[wr_ptr_q]     <= pc_in;
    end
  end

  fields_t head;

  assign head    = fields_mem_q[rd_ptr_q];
  assign op      = head.op;
  assign func    = head.func;
  assign sftamt  = head.sftamt;
  assign rs      = head.rs;
  assign rt      = head.rt;
  assign rd      = head.rd;
  assign immd16  = head.immd16;
  assign iclass  = head.iclass;
  assign imm_ext = imm_mem_q[rd_ptr_q];
  assign jtarget = jt_mem_q[rd_ptr_q];
  assign pc_out  = pc_mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, handshake corner sequences and
// random traffic against a queue-based reference model.
module tb_decode_stage;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       ins = '0;
  logic [PC_W-1:0]   pc_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [5:0]        op, func;
  logic [4:0]        sftamt, rs, rt, rd;
  logic [15:0]       immd16;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   jtarget;
  logic [1:0]        iclass;
  logic [PC_W-1:0]   pc_out;
  logic [CNT_W-1:0]  count;

  decode_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .ins(ins), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .func(func), .sftamt(sftamt), .rs(rs), .rt(rt), .rd(rd),
    .immd16(immd16), .imm_ext(imm_ext), .jtarget(jtarget), .iclass(iclass),
    .pc_out(pc_out), .count(count)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string tag = "init";

  typedef struct { logic [31:0] ins; logic [31:0] pc; } entry_t;
  entry_t model_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  // Reference decode rules expressed with plain arithmetic.
  function automatic int m_iclass(input logic [31:0] w);
    int o;
    o = int'(w >> 26);
    if (o == 0) return 0;
    if (o == 2 || o == 3) return 2;
    if (o >= 60) return 3;
    return 1;
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] w);
    int o, imm;
    o   = int'(w >> 26);
    imm = int'(w & 32'hFFFF);
    if (o == 12 || o == 13 || o == 14) return 32'(imm);
    if (o == 15) return 32'(imm) << 16;
    if (imm >= 32768) return 32'(imm - 65536);
    return 32'(imm);
  endfunction

  function automatic logic [31:0] m_jt(input logic [31:0] w, input logic [31:0] pc);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
  endfunction

  task automatic check_state();
    entry_t e;
    chk("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    chk("in_ready",  64'(in_ready),  64'(model_q.size() != DEPTH));
    chk("count",     64'(count),     64'(model_q.size()));
    if (model_q.size() != 0) begin
      e = model_q[0];
      chk("op",      64'(op),      64'(e.ins >> 26));
      chk("rs",      64'(rs),      64'((e.ins >> 21) & 31));
      chk("rt",      64'(rt),      64'((e.ins >> 16) & 31));
      chk("rd",      64'(rd),      64'((e.ins >> 11) & 31));
      chk("sftamt",  64'(sftamt),  64'((e.ins >> 6) & 31));
      chk("func",    64'(func),    64'(e.ins & 63));
      chk("immd16",  64'(immd16),  64'(e.ins & 32'hFFFF));
      chk("imm_ext", 64'(imm_ext), 64'(m_imm(e.ins)));
      chk("jtarget", 64'(jtarget), 64'(m_jt(e.ins, e.pc)));
      chk("iclass",  64'(iclass),  64'(m_iclass(e.ins)));
      chk("pc_out",  64'(pc_out),  64'(e.pc));
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit m_push, m_pop;
    in_valid = iv; ins = w; pc_in = pc; out_ready = ordy; flush = fl;
    m_push = iv && (model_q.size() < DEPTH) && !fl;
    m_pop  = (model_q.size() > 0) && ordy && !fl;
    @(posedge clk);
    #1;
    if (reset || fl) model_q.delete();
    else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back('{w, pc});
    end
    check_state();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [1:0]  iclass;
    logic [31:0] imm;
    logic [31:0] jt;
  } vec_t;

  vec_t vecs[10];
  logic [31:0] fill_pc[DEPTH];
  logic [5:0]  op_tab[13];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h012A4020, 32'h0000_0100, 2'b00, 32'h0000_4020, 32'h04A9_0080};
    vecs[1] = '{32'h2128FFFF, 32'h0000_0000, 2'b01, 32'hFFFF_FFFF, 32'h04A3_FFFC};
    vecs[2] = '{32'h3528FFFF, 32'h0000_0000, 2'b01, 32'h0000_FFFF, 32'h04A3_FFFC};
    vecs[3] = '{32'h3C081234, 32'h0000_0000, 2'b01, 32'h1234_0000, 32'h0020_48D0};
    vecs[4] = '{32'h08000040, 32'h3FFF_FFFC, 2'b10, 32'h0000_0040, 32'h4000_0100};
    vecs[5] = '{32'h0C000001, 32'hFFFF_FFFC, 2'b10, 32'h0000_0001, 32'h0000_0004};
    vecs[6] = '{32'hFC000000, 32'h0000_0000, 2'b11, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{32'h300A8000, 32'h0000_0000, 2'b01, 32'h0000_8000, 32'h002A_0000};
    vecs[8] = '{32'h24018000, 32'h0000_0000, 2'b01, 32'hFFFF_8000, 32'h0006_0000};
    vecs[9] = '{32'h39EF7FFF, 32'h0000_0000, 2'b01, 32'h0000_7FFF, 32'h07BD_FFFC};
    op_tab = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
               6'h3F, 6'h3C, 6'h23, 6'h2B, 6'h04};

    tag = "reset";
    do_reset();
    chk("count", 64'(count), 64'd0);
    chk("out_valid", 64'(out_valid), 64'd0);
    chk("in_ready", 64'(in_ready), 64'd1);

    // First word appears at the head one cycle after the push.
    tag = "add";
    cycle(1'b1, 32'h012A4020, 32'h100, 1'b0, 1'b0);
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("iclass", 64'(iclass), 64'd0);
    chk("rs", 64'(rs), 64'd9);
    chk("rt", 64'(rt), 64'd10);
    chk("rd", 64'(rd), 64'd8);
    chk("func", 64'(func), 64'h20);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      cycle(1'b1, vecs[i].ins, vecs[i].pc, 1'b0, 1'b0);
      chk("tbl_iclass", 64'(iclass), 64'(vecs[i].iclass));
      chk("tbl_imm", 64'(imm_ext), 64'(vecs[i].imm));
      chk("tbl_jt", 64'(jtarget), 64'(vecs[i].jt));
      chk("tbl_pc", 64'(pc_out), 64'(vecs[i].pc));
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Fill, then simultaneous pop and push while full: push refused.
    tag = "full";
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      fill_pc[i] = 32'h2000 + 32'(i * 4);
      cycle(1'b1, 32'h20000000 + 32'(i), fill_pc[i], 1'b0, 1'b0);
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'(DEPTH));
    cycle(1'b1, 32'h2000_0099, 32'h9999, 1'b1, 1'b0);
    chk("after_in_ready", 64'(in_ready), 64'd1);
    chk("after_count", 64'(count), 64'(DEPTH - 1));
    for (int i = 1; i < DEPTH; i++) begin
      chk("order_pc", 64'(pc_out), 64'(fill_pc[i]));
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("drained", 64'(out_valid), 64'd0);

    // Continuous streaming across several pointer wraps.
    tag = "stream";
    do_reset();
    begin
      int n_out;
      logic [31:0] r;
      n_out = 0;
      for (int i = 0; i < 3 * DEPTH + 4; i++) begin
        if (out_valid) n_out++;
        r = $urandom();
        cycle(1'b1, r, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
        chk("stream_pc", 64'(pc_out), 64'(32'h1000 + 32'(i * 4)));
      end
      chk("stream_pops", 64'(n_out), 64'(3 * DEPTH + 3));
    end

    // Flush with a word offered: everything gone, offered word dropped.
    tag = "flush";
    do_reset();
    cycle(1'b1, 32'h012A4020, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h2128FFFF, 32'h304, 1'b0, 1'b0);
    chk("pre_count", 64'(count), 64'd2);
    cycle(1'b1, 32'h3528FFFF, 32'h308, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_absent", 64'(out_valid), 64'd0);

    tag = "midreset";
    cycle(1'b1, 32'h012A4020, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 32'h2128FFFF, 32'h404, 1'b0, 1'b0);
    chk("pre_count", 64'(count), 64'd2);
    reset = 1'b1;
    cycle(1'b1, 32'h3528FFFF, 32'h408, 1'b0, 1'b1);
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("rst_absent", 64'(out_valid), 64'd0);

    // Random traffic with occasional flushes.
    tag = "random";
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r, w, pc;
      logic iv, ordy, fl;
      r    = $urandom();
      w    = {op_tab[$urandom_range(0, 12)], r[25:0]};
      pc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (r & 32'hC)) : ($urandom() & 32'hFFFF_FFFC);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      cycle(iv, w, pc, ordy, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
